// File: rtl/parse_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : parse_unit_pkg
// Description : Instruction word geometry and field positions, shared by the
//               fetch, parse and decode stages.
// Revision    : 1.0 - initial release
// ============================================================================
package parse_unit_pkg;

    localparam int unsigned c_bytes_per_instr = 4;
    localparam int unsigned c_instr_width     = 8 * c_bytes_per_instr;
    localparam int unsigned c_pc_width        = 16;

    // Field bit positions within the 32-bit instruction word
    localparam int unsigned c_format_bit      = 29;
    localparam int unsigned c_branch_bit      = 28;
    localparam int unsigned c_opcode_msb      = 27;
    localparam int unsigned c_opcode_lsb      = 21;
    localparam int unsigned c_primary_msb     = 20;
    localparam int unsigned c_primary_lsb     = 16;
    localparam int unsigned c_secondary_msb   = 15;
    localparam int unsigned c_secondary_lsb   = 0;

    // Bits 31:30 are reserved and must be zero in a legal instruction
    localparam logic [c_instr_width-1:0] c_reserved_mask = 32'hC000_0000;

    // True when any reserved bit of the word is set
    function automatic logic has_reserved(input logic [c_instr_width-1:0] word);
        return |(word & c_reserved_mask);
    endfunction

endpackage : parse_unit_pkg
`default_nettype wire

// File: rtl/parse_fifo.sv
`default_nettype none
// ============================================================================
// Module      : parse_fifo
// Description : Queue of parsed instruction entries. First-word-fall-through
//               head, simultaneous push/pop allowed when full, flush clears.
// Revision    : 1.0 - initial release
// ============================================================================
module parse_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_pop_ok  = pop_i & ~w_empty;
    // A full queue can still take a push when the head leaves on the same edge
    assign w_push_ok = push_i & (~w_full | w_pop_ok);

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array; contents are meaningless while the queue is empty
    always_ff @(posedge clock_i) begin
        if (w_push_ok && !flush_i) begin
            r_mem[r_wr_ptr] <= data_i;
        end
    end

    assign data_o  = r_mem[r_rd_ptr];
    assign valid_o = ~w_empty;
    assign full_o  = w_full;

endmodule : parse_fifo
`default_nettype wire

// File: rtl/parse_unit.sv
`default_nettype none
// ============================================================================
// Module      : parse_unit
// Description : Assembles fetched bytes (big-endian, PC-contiguous) into
//               instruction words, queues them with their start PC and
//               decodes the head entry into instruction fields.
// Revision    : 1.0 - initial release
// ============================================================================
module parse_unit
    import parse_unit_pkg::*;
#(
    parameter int unsigned BYTES_PER_INSTR = c_bytes_per_instr,
    parameter int unsigned FIFO_DEPTH      = 4
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        enable_i,
    input  logic [15:0] PC_i,
    input  logic [7:0]  data_i,
    input  logic        flush_i,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [15:0] PC_o,
    output logic        format_o,
    output logic        branch_o,
    output logic [6:0]  opcode_o,
    output logic [4:0]  primary_o,
    output logic [15:0] secondary_o,
    output logic        illegal_o,
    output logic        overflow_o
);

    localparam int unsigned WORD_W  = 8 * BYTES_PER_INSTR;
    localparam int unsigned ENTRY_W = WORD_W + c_pc_width;
    localparam int unsigned CNT_W   = (BYTES_PER_INSTR > 1) ? $clog2(BYTES_PER_INSTR) : 1;
    localparam int unsigned LAST    = BYTES_PER_INSTR - 1;

    logic [CNT_W-1:0]   r_byte_cnt;
    logic [15:0]        r_exp_pc;
    logic [15:0]        r_start_pc;
    logic [WORD_W-1:0]  r_word;
    logic               r_overflow;

    logic               w_accept;
    logic               w_restart;
    logic               w_last;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_fifo_valid;
    logic               w_fifo_full;
    logic [WORD_W-1:0]  w_next_word;
    logic [ENTRY_W-1:0] w_push_entry;
    logic [ENTRY_W-1:0] w_head_entry;
    logic [WORD_W-1:0]  w_head_word;
    logic [15:0]        w_head_pc;

    // Shifting left places the first byte in the top lane after a full word
    assign w_next_word  = {r_word[WORD_W-9:0], data_i};
    assign w_accept     = enable_i & ~flush_i;
    // A byte starts a new word at count 0 or when it breaks PC contiguity
    assign w_restart    = (r_byte_cnt == '0) || (PC_i != r_exp_pc);
    assign w_last       = ~w_restart && (r_byte_cnt == CNT_W'(LAST));
    assign w_push       = w_accept & w_last;
    assign w_pop        = w_fifo_valid & ready_i;
    assign w_drop       = w_push & w_fifo_full & ~w_pop;
    assign w_push_entry = {w_next_word, r_start_pc};

    // Byte assembler: counter, expected next PC and start PC of the word
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_byte_cnt <= '0;
            r_exp_pc   <= '0;
            r_start_pc <= '0;
            r_word     <= '0;
        end else if (flush_i) begin
            r_byte_cnt <= '0;
        end else if (w_accept) begin
            r_word   <= w_next_word;
            r_exp_pc <= PC_i + 16'd1;
            if (w_restart) begin
                r_start_pc <= PC_i;
                r_byte_cnt <= CNT_W'(1);
            end else if (w_last) begin
                r_byte_cnt <= '0;
            end else begin
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end
        end
    end

    // Sticky record that a completed word was lost to a full queue
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

    parse_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .flush_i (flush_i),
        .push_i  (w_push),
        .data_i  (w_push_entry),
        .pop_i   (w_pop),
        .data_o  (w_head_entry),
        .valid_o (w_fifo_valid),
        .full_o  (w_fifo_full)
    );

    // Fields are forced to zero when nothing valid is at the head
    assign w_head_word = w_fifo_valid ? w_head_entry[ENTRY_W-1 -: WORD_W] : '0;
    assign w_head_pc   = w_fifo_valid ? w_head_entry[c_pc_width-1:0]      : '0;

    assign valid_o     = w_fifo_valid;
    assign PC_o        = w_head_pc;
    assign format_o    = w_head_word[c_format_bit];
    assign branch_o    = w_head_word[c_branch_bit];
    assign opcode_o    = w_head_word[c_opcode_msb:c_opcode_lsb];
    assign primary_o   = w_head_word[c_primary_msb:c_primary_lsb];
    assign secondary_o = w_head_word[c_secondary_msb:c_secondary_lsb];
    assign illegal_o   = w_fifo_valid & has_reserved(w_head_word);
    assign overflow_o  = r_overflow;

endmodule : parse_unit
`default_nettype wire
